// File: rtl/fp_wire.sv
// Shared FP wire package.
// Holds the compare op codes, the canonical quiet NaN, the comparator
// request/answer structs and the S1 register layout of fp_cmp_issue.
package fp_wire;

    localparam logic [2:0] FP_CMP_FLE  = 3'd0;
    localparam logic [2:0] FP_CMP_FLT  = 3'd1;
    localparam logic [2:0] FP_CMP_FEQ  = 3'd2;
    localparam logic [2:0] FP_CMP_FMIN = 3'd3;
    localparam logic [2:0] FP_CMP_FMAX = 3'd4;

    localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;

    // Comparator request: extended operands, compare mode and class vectors.
    typedef struct packed {
        logic [32:0] data1;
        logic [32:0] data2;
        logic [2:0]  rm;
        logic [9:0]  class1;
        logic [9:0]  class2;
    } fp_cmp_in_type;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  flags;
    } fp_cmp_out_type;

    // Contents of the issue stage register (valid bit kept separately).
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] raw1;
        logic [31:0] raw2;
        logic [32:0] ext1;
        logic [32:0] ext2;
        logic [9:0]  class1;
        logic [9:0]  class2;
    } fp_cmp_issue_reg_type;

    // Sign moves to bit 32; [31:0] is the unsigned magnitude used for ordering.
    function automatic logic [32:0] fp_extend(input logic [31:0] a);
        return {a[31], 1'b0, a[30:0]};
    endfunction

endpackage

// File: rtl/fp_class.sv
// Single-precision classifier.
// Ports: i_data (32-bit IEEE-754 single) -> o_class (10-bit one-hot):
//   0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0,
//   5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN.
module fp_class (
    input  logic [31:0] i_data,
    output logic [9:0]  o_class
);
    logic w_sign;
    logic w_exp_ones;
    logic w_exp_zero;
    logic w_mant_zero;
    logic w_inf;
    logic w_norm;
    logic w_sub;
    logic w_zero;
    logic w_nan;

    assign w_sign      = i_data[31];
    assign w_exp_ones  = &i_data[30:23];
    assign w_exp_zero  = ~|i_data[30:23];
    assign w_mant_zero = ~|i_data[22:0];

    assign w_inf  = w_exp_ones & w_mant_zero;
    assign w_norm = ~w_exp_ones & ~w_exp_zero;
    assign w_sub  = w_exp_zero & ~w_mant_zero;
    assign w_zero = w_exp_zero & w_mant_zero;
    assign w_nan  = w_exp_ones & ~w_mant_zero;

    assign o_class[0] = w_sign & w_inf;
    assign o_class[1] = w_sign & w_norm;
    assign o_class[2] = w_sign & w_sub;
    assign o_class[3] = w_sign & w_zero;
    assign o_class[4] = ~w_sign & w_zero;
    assign o_class[5] = ~w_sign & w_sub;
    assign o_class[6] = ~w_sign & w_norm;
    assign o_class[7] = ~w_sign & w_inf;
    // NaN sign is irrelevant; the quiet bit is mantissa MSB.
    assign o_class[8] = w_nan & ~i_data[22];
    assign o_class[9] = w_nan & i_data[22];
endmodule

// File: rtl/fp_cmp.sv
// Combinational single-precision comparator.
// Ports: i_cmp_in (extended operands, rm, class vectors) -> o_cmp_out.
//   rm 0 fle, 1 flt, 2 feq; other rm values answer 0 with no flags.
//   Result is in bit 0; flags are {NV,DZ,OF,UF,NX}.
module fp_cmp
    import fp_wire::*;
(
    input  fp_cmp_in_type  i_cmp_in,
    output fp_cmp_out_type o_cmp_out
);
    logic w_nan_any;
    logic w_snan_any;
    logic w_both_zero;
    logic w_eq;
    logic w_lt;
    logic w_s1;
    logic w_s2;
    logic [31:0] w_m1;
    logic [31:0] w_m2;

    assign w_s1 = i_cmp_in.data1[32];
    assign w_s2 = i_cmp_in.data2[32];
    assign w_m1 = i_cmp_in.data1[31:0];
    assign w_m2 = i_cmp_in.data2[31:0];

    assign w_nan_any  = i_cmp_in.class1[8] | i_cmp_in.class1[9] |
                        i_cmp_in.class2[8] | i_cmp_in.class2[9];
    assign w_snan_any = i_cmp_in.class1[8] | i_cmp_in.class2[8];
    assign w_both_zero = (i_cmp_in.class1[3] | i_cmp_in.class1[4]) &
                         (i_cmp_in.class2[3] | i_cmp_in.class2[4]);

    // +0 and -0 compare equal; otherwise equality is bitwise.
    assign w_eq = w_both_zero | (i_cmp_in.data1 == i_cmp_in.data2);

    always_comb begin
        w_lt = 1'b0;
        if (w_s1 != w_s2)
            w_lt = w_s1 & ~w_both_zero;
        else if (!w_s1)
            w_lt = w_m1 < w_m2;
        else
            w_lt = w_m2 < w_m1;
    end

    always_comb begin
        o_cmp_out = '0;
        case (i_cmp_in.rm)
            3'd0: begin
                o_cmp_out.result[0] = (w_lt | w_eq) & ~w_nan_any;
                o_cmp_out.flags[4]  = w_nan_any;
            end
            3'd1: begin
                o_cmp_out.result[0] = w_lt & ~w_nan_any;
                o_cmp_out.flags[4]  = w_nan_any;
            end
            3'd2: begin
                o_cmp_out.result[0] = w_eq & ~w_nan_any;
                o_cmp_out.flags[4]  = w_snan_any;
            end
            default: o_cmp_out = '0;
        endcase
    end
endmodule

// File: rtl/fp_cmp_issue.sv
// FP compare / min / max issue front end.
// Ports:
//   clock, reset (async, active-low)
//   req_valid/req_ready, req_op[2:0], req_data1/2[31:0] : request side
//   flush : drop everything in flight
//   rsp_valid/rsp_ready, rsp_result[31:0], rsp_flags[4:0] : response side
// Two stages: S1 holds the classified request and feeds the comparator and
// min/max select combinationally; S2 registers the answer onto rsp_*.
module fp_cmp_issue
    import fp_wire::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_data1,
    input  logic [31:0] req_data2,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_flags
);
    fp_cmp_issue_reg_type r_s1;
    logic                 r_v1;
    logic                 r_v2;
    logic [31:0]          r_result;
    logic [4:0]           r_flags;

    logic [9:0]     w_class1;
    logic [9:0]     w_class2;
    fp_cmp_in_type  w_cmp_in;
    fp_cmp_out_type w_cmp_out;
    logic           w_adv2;
    logic           w_accept;
    logic [31:0]    w_result;
    logic [4:0]     w_flags;

    fp_class u_class1 (.i_data(req_data1), .o_class(w_class1));
    fp_class u_class2 (.i_data(req_data2), .o_class(w_class2));

    assign w_adv2    = r_v1 & (~r_v2 | rsp_ready);
    assign req_ready = ~flush & (~r_v1 | w_adv2);
    assign w_accept  = req_valid & req_ready;

    // min/max reuse the flt ordering; illegal ops get a harmless mode.
    always_comb begin
        w_cmp_in        = '0;
        w_cmp_in.data1  = r_s1.ext1;
        w_cmp_in.data2  = r_s1.ext2;
        w_cmp_in.class1 = r_s1.class1;
        w_cmp_in.class2 = r_s1.class2;
        case (r_s1.op)
            FP_CMP_FLE:  w_cmp_in.rm = 3'd0;
            FP_CMP_FLT:  w_cmp_in.rm = 3'd1;
            FP_CMP_FEQ:  w_cmp_in.rm = 3'd2;
            FP_CMP_FMIN: w_cmp_in.rm = 3'd1;
            FP_CMP_FMAX: w_cmp_in.rm = 3'd1;
            default:     w_cmp_in.rm = 3'd0;
        endcase
    end

    fp_cmp u_cmp (.i_cmp_in(w_cmp_in), .o_cmp_out(w_cmp_out));

    logic w_nan1;
    logic w_nan2;
    logic w_zero_mix;
    logic w_is_min;
    logic w_lt;

    assign w_nan1     = r_s1.class1[8] | r_s1.class1[9];
    assign w_nan2     = r_s1.class2[8] | r_s1.class2[9];
    assign w_zero_mix = (r_s1.class1[3] & r_s1.class2[4]) |
                        (r_s1.class1[4] & r_s1.class2[3]);
    assign w_is_min   = (r_s1.op == FP_CMP_FMIN);
    assign w_lt       = w_cmp_out.result[0];

    always_comb begin
        w_result = '0;
        w_flags  = '0;
        case (r_s1.op)
            FP_CMP_FLE, FP_CMP_FLT, FP_CMP_FEQ: begin
                w_result = w_cmp_out.result;
                w_flags  = w_cmp_out.flags;
            end
            FP_CMP_FMIN, FP_CMP_FMAX: begin
                w_flags[4] = r_s1.class1[8] | r_s1.class2[8];
                if (w_nan1 & w_nan2)
                    w_result = FP_CANON_NAN;
                else if (w_nan1)
                    w_result = r_s1.raw2;
                else if (w_nan2)
                    w_result = r_s1.raw1;
                else if (w_zero_mix)
                    // -0 is the smaller of the two zeros.
                    w_result = w_is_min ? 32'h8000_0000 : 32'h0000_0000;
                else if (w_is_min)
                    w_result = w_lt ? r_s1.raw1 : r_s1.raw2;
                else
                    w_result = w_lt ? r_s1.raw2 : r_s1.raw1;
            end
            default: begin
                w_result = '0;
                w_flags  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_v1 <= 1'b0;
            r_s1 <= '0;
        end else if (flush) begin
            r_v1 <= 1'b0;
        end else if (w_accept) begin
            r_v1        <= 1'b1;
            r_s1.op     <= req_op;
            r_s1.raw1   <= req_data1;
            r_s1.raw2   <= req_data2;
            r_s1.ext1   <= fp_extend(req_data1);
            r_s1.ext2   <= fp_extend(req_data2);
            r_s1.class1 <= w_class1;
            r_s1.class2 <= w_class2;
        end else if (w_adv2) begin
            r_v1 <= 1'b0;
        end
    end

    // Result/flags only change on advance, so they hold under backpressure.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_v2     <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else if (flush) begin
            r_v2 <= 1'b0;
        end else if (w_adv2) begin
            r_v2     <= 1'b1;
            r_result <= w_result;
            r_flags  <= w_flags;
        end else if (rsp_ready) begin
            r_v2 <= 1'b0;
        end
    end

    assign rsp_valid  = r_v2;
    assign rsp_result = r_result;
    assign rsp_flags  = r_flags;
endmodule
